// File: rtl/st7789_spi_rx_if.sv
// Pin and result bundle for the ST7789 write-only SPI receiver.
// The master side drives the panel pins; the slave side is the receiver.
interface st7789_spi_rx_if;
  logic        sda_i;
  logic        scl_i;
  logic        dc_i;
  logic        res_ni;
  logic        byte_valid_o;
  logic [7:0]  byte_o;
  logic        byte_dc_o;
  logic        pix_valid_o;
  logic [7:0]  pix_x_o;
  logic [7:0]  pix_y_o;
  logic [15:0] pix_data_o;
  logic        sleep_out_o;
  logic        disp_on_o;
  logic        inv_on_o;
  logic        frame_err_o;

  modport master (
    output sda_i, scl_i, dc_i, res_ni,
    input  byte_valid_o, byte_o, byte_dc_o, pix_valid_o, pix_x_o, pix_y_o,
           pix_data_o, sleep_out_o, disp_on_o, inv_on_o, frame_err_o
  );

  modport slave (
    input  sda_i, scl_i, dc_i, res_ni,
    output byte_valid_o, byte_o, byte_dc_o, pix_valid_o, pix_x_o, pix_y_o,
           pix_data_o, sleep_out_o, disp_on_o, inv_on_o, frame_err_o
  );
endinterface

// File: rtl/st7789_spi_rx.sv
// Oversampling receiver for the ST7789 4-wire SPI link: reframes bytes,
// tracks the CASET/RASET window and turns RAMWR data into addressed RGB565 pixels.
module st7789_spi_rx #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 240,
  parameter int TIMEOUT = 1024
) (
  input logic           clk_i,
  input logic           rst_i,
  st7789_spi_rx_if.slave bus
);
  localparam int              IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]   IDLE_MAX = IW'(TIMEOUT);
  localparam logic [7:0]      XE_DEF   = 8'(WIDTH - 1);
  localparam logic [7:0]      YE_DEF   = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_COL, S_ROW, S_PIX, S_SKIP} state_t;

  // Synchroniser stages, bit order {res, dc, scl, sda}
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          scl_s3_q, scl_s3_d;
  logic [6:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_dc_q, byte_dc_d;
  state_t        state_q, state_d;
  logic [1:0]    pidx_q, pidx_d;
  logic [7:0]    pstart_q, pstart_d;
  logic [7:0]    xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic          half_q, half_d;
  logic [7:0]    hi_q, hi_d;
  logic          pix_valid_q, pix_valid_d;
  logic [7:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          sleep_q, sleep_d, disp_q, disp_d, inv_q, inv_d, ferr_q, ferr_d;

  logic sda_s2, dc_s2, res_s2, rise;

  assign sda_s2 = s2_q[0];
  assign dc_s2  = s2_q[2];
  assign res_s2 = s2_q[3];
  assign rise   = s2_q[1] & ~scl_s3_q;

  always_comb begin
    s1_d         = {bus.res_ni, bus.dc_i, bus.scl_i, bus.sda_i};
    s2_d         = s1_q;
    scl_s3_d     = s2_q[1];
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    idle_d       = idle_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    state_d      = state_q;
    pidx_d       = pidx_q;
    pstart_d     = pstart_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    half_d       = half_q;
    hi_d         = hi_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_data_d   = pix_data_q;
    sleep_d      = sleep_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    ferr_d       = ferr_q;

    if (rise) begin
      shift_d = {shift_q[5:0], sda_s2};
      idle_d  = '0;
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d    = 3'd0;
        byte_valid_d = 1'b1;
        byte_d       = {shift_q, sda_s2};
        byte_dc_d    = dc_s2;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else begin
      if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_MAX && bit_cnt_q != 3'd0) begin
        bit_cnt_d = 3'd0;
        ferr_d    = 1'b1;
      end
    end

    if (byte_valid_q) begin
      if (!byte_dc_q) begin
        state_d = S_IDLE;
        pidx_d  = 2'd0;
        case (byte_q)
          8'h2A: state_d = S_COL;
          8'h2B: state_d = S_ROW;
          8'h2C: begin
            state_d = S_PIX;
            cur_x_d = xs_q;
            cur_y_d = ys_q;
            half_d  = 1'b0;
          end
          8'h01: begin
            xs_d    = 8'd0;
            xe_d    = XE_DEF;
            ys_d    = 8'd0;
            ye_d    = YE_DEF;
            sleep_d = 1'b0;
            disp_d  = 1'b0;
            inv_d   = 1'b0;
          end
          8'h10: sleep_d = 1'b0;
          8'h11: sleep_d = 1'b1;
          8'h20: inv_d   = 1'b0;
          8'h21: inv_d   = 1'b1;
          8'h28: disp_d  = 1'b0;
          8'h29: disp_d  = 1'b1;
          default: state_d = S_SKIP;
        endcase
      end else begin
        case (state_q)
          S_COL, S_ROW: begin
            // Only the low byte of each 16-bit coordinate is meaningful here
            pidx_d = pidx_q + 2'd1;
            if (pidx_q == 2'd1) pstart_d = byte_q;
            if (pidx_q == 2'd3) begin
              if (state_q == S_COL) begin
                xs_d = pstart_q;
                xe_d = byte_q;
              end else begin
                ys_d = pstart_q;
                ye_d = byte_q;
              end
              state_d = S_SKIP;
            end
          end
          S_PIX: begin
            half_d = ~half_q;
            if (!half_q) begin
              hi_d = byte_q;
            end else if (xs_q > xe_q || ys_q > ye_q) begin
              ferr_d = 1'b1;
            end else begin
              pix_valid_d = 1'b1;
              pix_x_d     = cur_x_q;
              pix_y_d     = cur_y_q;
              pix_data_d  = {hi_q, byte_q};
              if (cur_x_q == xe_q) begin
                cur_x_d = xs_q;
                cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
              end else begin
                cur_x_d = cur_x_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Panel reset behaves like rst_i but keeps the error flag and last byte
    if (!res_s2) begin
      bit_cnt_d    = 3'd0;
      idle_d       = '0;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      byte_dc_d    = byte_dc_q;
      state_d      = S_IDLE;
      pidx_d       = 2'd0;
      xs_d         = 8'd0;
      xe_d         = XE_DEF;
      ys_d         = 8'd0;
      ye_d         = YE_DEF;
      cur_x_d      = 8'd0;
      cur_y_d      = 8'd0;
      half_d       = 1'b0;
      pix_valid_d  = 1'b0;
      pix_x_d      = 8'd0;
      pix_y_d      = 8'd0;
      pix_data_d   = 16'd0;
      sleep_d      = 1'b0;
      disp_d       = 1'b0;
      inv_d        = 1'b0;
      ferr_d       = ferr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q         <= 4'b1010;
      s2_q         <= 4'b1010;
      scl_s3_q     <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      state_q      <= S_IDLE;
      pidx_q       <= '0;
      pstart_q     <= '0;
      xs_q         <= '0;
      xe_q         <= XE_DEF;
      ys_q         <= '0;
      ye_q         <= YE_DEF;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      half_q       <= 1'b0;
      hi_q         <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      sleep_q      <= 1'b0;
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      scl_s3_q     <= scl_s3_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      state_q      <= state_d;
      pidx_q       <= pidx_d;
      pstart_q     <= pstart_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      half_q       <= half_d;
      hi_q         <= hi_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
      sleep_q      <= sleep_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      ferr_q       <= ferr_d;
    end
  end

  assign bus.byte_valid_o = byte_valid_q;
  assign bus.byte_o       = byte_q;
  assign bus.byte_dc_o    = byte_dc_q;
  assign bus.pix_valid_o  = pix_valid_q;
  assign bus.pix_x_o      = pix_x_q;
  assign bus.pix_y_o      = pix_y_q;
  assign bus.pix_data_o   = pix_data_q;
  assign bus.sleep_out_o  = sleep_q;
  assign bus.disp_on_o    = disp_q;
  assign bus.inv_on_o     = inv_q;
  assign bus.frame_err_o  = ferr_q;
endmodule
